// File: rtl/tlb_maint_pkg.sv
// Shared definitions for the TLB maintenance engine: op/state encodings,
// entry geometry and the entry packing helpers.
package tlb_maint_pkg;

  localparam int TLB_DATA_WIDTH  = 63;
  localparam int TLB_INDEX_NUM   = 16;
  localparam int TLB_INDEX_WIDTH = $clog2(TLB_INDEX_NUM);

  localparam logic [TLB_INDEX_WIDTH-1:0] IDX_MAX = TLB_INDEX_WIDTH'(TLB_INDEX_NUM - 1);

  // Entry field positions inside a packed TLB entry.
  localparam int VPN2_HI = 62;
  localparam int VPN2_LO = 44;
  localparam int PFN1_HI = 43;
  localparam int PFN1_LO = 24;
  localparam int D1_BIT  = 23;
  localparam int V1_BIT  = 22;
  localparam int PFN0_HI = 21;
  localparam int PFN0_LO = 2;
  localparam int D0_BIT  = 1;
  localparam int V0_BIT  = 0;

  typedef enum logic [1:0] {
    OP_TLBWI = 2'b00,
    OP_TLBWR = 2'b01,
    OP_TLBP  = 2'b10,
    OP_TLBR  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_PROBE = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef logic [TLB_DATA_WIDTH-1:0] entry_t;

  function automatic entry_t pack_entry(input logic [18:0] vpn2,
                                        input logic [19:0] pfn1, input logic d1, input logic v1,
                                        input logic [19:0] pfn0, input logic d0, input logic v0);
    return {vpn2, pfn1, d1, v1, pfn0, d0, v0};
  endfunction

  // Rebuilds the CP0 EntryLo image of one page half.
  function automatic logic [31:0] entrylo_image(input logic [19:0] pfn, input logic d,
                                                input logic v);
    return {6'b0, pfn, 3'b0, d, v, 1'b0};
  endfunction

endpackage

// File: rtl/tlb_maint_random.sv
// CP0 Random register: counts down every cycle and wraps to the top entry
// once it reaches (or sits below) the Wired boundary.
module tlb_random
  import tlb_maint_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TLB_INDEX_WIDTH-1:0] wired,
  output logic [TLB_INDEX_WIDTH-1:0] random
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst) begin
      random <= IDX_MAX;
    end else if (random <= wired) begin
      random <= IDX_MAX;
    end else begin
      random <= random - 1'b1;
    end
  end

endmodule

// File: rtl/tlb_maint.sv
// TLB maintenance engine: sequences TLBWI/TLBWR/TLBP/TLBR against an external
// TLB array through one write port and one combinational read port.
module tlb_maint
  import tlb_maint_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_valid,
  input  logic [1:0]                 op,
  input  logic [31:0]                cp0_entryhi,
  input  logic [31:0]                cp0_entrylo0,
  input  logic [31:0]                cp0_entrylo1,
  input  logic [TLB_INDEX_WIDTH-1:0] cp0_index,
  input  logic [TLB_INDEX_WIDTH-1:0] cp0_wired,
  output logic                       tlb_we,
  output logic [TLB_INDEX_WIDTH-1:0] tlb_index,
  output logic [TLB_DATA_WIDTH-1:0]  tlb_data,
  output logic [TLB_INDEX_WIDTH-1:0] tlb_rd_index,
  input  logic [TLB_DATA_WIDTH-1:0]  tlb_rd_data,
  output logic                       busy,
  output logic                       done,
  output logic                       stallreq,
  output logic [TLB_INDEX_WIDTH-1:0] cp0_random,
  output logic [31:0]                probe_result,
  output logic [31:0]                rd_entryhi,
  output logic [31:0]                rd_entrylo0,
  output logic [31:0]                rd_entrylo1
);

  state_e                     state, state_next;
  entry_t                     entry_q;
  logic [TLB_INDEX_WIDTH-1:0] target_q;
  logic [TLB_INDEX_WIDTH-1:0] scan_q;
  logic                       probe_hit;
  logic                       accept;
  entry_t                     entry_in;
  logic                       unused_cp0_bits;

  tlb_random u_random (
    .clk    (clk),
    .rst    (rst),
    .wired  (cp0_wired),
    .random (cp0_random)
  );

  assign entry_in = pack_entry(cp0_entryhi[31:13],
                               cp0_entrylo1[25:6], cp0_entrylo1[2], cp0_entrylo1[1],
                               cp0_entrylo0[25:6], cp0_entrylo0[2], cp0_entrylo0[1]);

  // ASID, cache attributes and G bits are not held in this TLB format.
  assign unused_cp0_bits = ^{cp0_entryhi[12:0],
                             cp0_entrylo0[31:26], cp0_entrylo0[5:3], cp0_entrylo0[0],
                             cp0_entrylo1[31:26], cp0_entrylo1[5:3], cp0_entrylo1[0]};

  assign accept    = (state == ST_IDLE) && op_valid;
  assign probe_hit = tlb_rd_data[VPN2_HI:VPN2_LO] == entry_q[VPN2_HI:VPN2_LO];
  assign stallreq  = busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      entry_q      <= '0;
      target_q     <= '0;
      scan_q       <= '0;
      probe_result <= '0;
      rd_entryhi   <= '0;
      rd_entrylo0  <= '0;
      rd_entrylo1  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        entry_q  <= entry_in;
        // TLBWR targets the Random value seen on the accepting edge.
        target_q <= (op_e'(op) == OP_TLBWR) ? cp0_random : cp0_index;
        scan_q   <= '0;
      end
      if (state == ST_PROBE) begin
        scan_q <= scan_q + 1'b1;
        if (probe_hit) begin
          probe_result <= {1'b0, 27'b0, scan_q};
        end else if (scan_q == IDX_MAX) begin
          probe_result <= 32'h8000_0000;
        end
      end
      if (state == ST_READ) begin
        rd_entryhi  <= {tlb_rd_data[VPN2_HI:VPN2_LO], 13'b0};
        rd_entrylo1 <= entrylo_image(tlb_rd_data[PFN1_HI:PFN1_LO],
                                     tlb_rd_data[D1_BIT], tlb_rd_data[V1_BIT]);
        rd_entrylo0 <= entrylo_image(tlb_rd_data[PFN0_HI:PFN0_LO],
                                     tlb_rd_data[D0_BIT], tlb_rd_data[V0_BIT]);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    tlb_we       = 1'b0;
    tlb_index    = '0;
    tlb_data     = '0;
    tlb_rd_index = '0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (op_valid) begin
          unique case (op_e'(op))
            OP_TLBWI, OP_TLBWR: state_next = ST_WRITE;
            OP_TLBP:            state_next = ST_PROBE;
            OP_TLBR:            state_next = ST_READ;
            default:            state_next = ST_IDLE;
          endcase
        end
      end
      ST_WRITE: begin
        busy       = 1'b1;
        tlb_we     = 1'b1;
        tlb_index  = target_q;
        tlb_data   = entry_q;
        state_next = ST_DONE;
      end
      ST_PROBE: begin
        busy         = 1'b1;
        tlb_rd_index = scan_q;
        if (probe_hit || scan_q == IDX_MAX) begin
          state_next = ST_DONE;
        end
      end
      ST_READ: begin
        busy         = 1'b1;
        tlb_rd_index = target_q;
        state_next   = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlb_maint.sv
// Self-checking bench for tlb_maint: a TLB array model on the ports, a Random
// reference model, and queued write/done expectations checked on the falling edge.
module tb_tlb_maint;
  import tlb_maint_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] cp0_entryhi = '0, cp0_entrylo0 = '0, cp0_entrylo1 = '0;
  logic [3:0]  cp0_index = '0, cp0_wired = 4'd12;
  logic        tlb_we, busy, done, stallreq;
  logic [3:0]  tlb_index, tlb_rd_index, cp0_random;
  logic [62:0] tlb_data, tlb_rd_data;
  logic [31:0] probe_result, rd_entryhi, rd_entrylo0, rd_entrylo1;

  logic [62:0] mem [16];
  assign tlb_rd_data = mem[tlb_rd_index];

  always #5 clk = ~clk;

  tlb_maint dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
    .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .cp0_index(cp0_index), .cp0_wired(cp0_wired),
    .tlb_we(tlb_we), .tlb_index(tlb_index), .tlb_data(tlb_data),
    .tlb_rd_index(tlb_rd_index), .tlb_rd_data(tlb_rd_data),
    .busy(busy), .done(done), .stallreq(stallreq), .cp0_random(cp0_random),
    .probe_result(probe_result), .rd_entryhi(rd_entryhi),
    .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1)
  );

  typedef struct {int cyc; logic [3:0] idx; logic [62:0] data;} wr_exp_t;
  typedef struct {int cyc; logic [1:0] op; logic [31:0] probe, hi, lo0, lo1;} dn_exp_t;

  wr_exp_t    wq[$];
  dn_exp_t    dq[$];
  wr_exp_t    w_e;
  dn_exp_t    d_e;
  int         cyc = 0, total = 0, passed = 0, done_cnt = 0, we_cnt = 0;
  logic [3:0] rnd_m = 4'd15;

  function automatic logic [62:0] exp_entry(input logic [31:0] hi, l0, l1);
    return {hi[31:13], l1[25:6], l1[2], l1[1], l0[25:6], l0[2], l0[1]};
  endfunction

  function automatic logic [31:0] exp_lo(input logic [31:0] l);
    return {6'b0, l[25:6], 3'b0, l[2], l[1], 1'b0};
  endfunction

  // TLB array write port, cycle counter and Random reference model.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tlb_we) mem[tlb_index] = tlb_data;
    if (!rst) rnd_m <= 4'd15;
    else if (rnd_m <= cp0_wired) rnd_m <= 4'd15;
    else rnd_m <= rnd_m - 4'd1;
  end

  always @(negedge clk) begin
    total++;
    if (cp0_random !== rnd_m) $display("FAIL random: got %0d expected %0d (cyc %0d)", cp0_random, rnd_m, cyc);
    else passed++;
    total++;
    if (stallreq !== busy) $display("FAIL stallreq: got %b expected %b", stallreq, busy);
    else passed++;
    if (tlb_we === 1'b1) begin
      we_cnt++;
      total++;
      if (wq.size() == 0) $display("FAIL unexpected_write: got idx %0d expected no write (cyc %0d)", tlb_index, cyc);
      else begin
        w_e = wq.pop_front();
        if (cyc !== w_e.cyc || tlb_index !== w_e.idx || tlb_data !== w_e.data)
          $display("FAIL write: got cyc %0d idx %0d data %h expected cyc %0d idx %0d data %h",
                   cyc, tlb_index, tlb_data, w_e.cyc, w_e.idx, w_e.data);
        else passed++;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      total++;
      if (dq.size() == 0) $display("FAIL unexpected_done: got done expected none (cyc %0d)", cyc);
      else begin
        d_e = dq.pop_front();
        if (cyc !== d_e.cyc) $display("FAIL done_cycle: got %0d expected %0d", cyc, d_e.cyc);
        else passed++;
        if (d_e.op == OP_TLBP) begin
          total++;
          if (probe_result !== d_e.probe) $display("FAIL probe_result: got %h expected %h", probe_result, d_e.probe);
          else passed++;
        end
        if (d_e.op == OP_TLBR) begin
          total++;
          if ({rd_entryhi, rd_entrylo1, rd_entrylo0} !== {d_e.hi, d_e.lo1, d_e.lo0})
            $display("FAIL tlbr_result: got %h %h %h expected %h %h %h", rd_entryhi, rd_entrylo1,
                     rd_entrylo0, d_e.hi, d_e.lo1, d_e.lo0);
          else passed++;
        end
      end
    end
  end

  task automatic issue(input op_e o, input logic [31:0] hi, l0, l1, input logic [3:0] idx,
                       output int d);
    op = o; cp0_entryhi = hi; cp0_entrylo0 = l0; cp0_entrylo1 = l1; cp0_index = idx;
    op_valid = 1'b1;
    d = cyc;
  endtask

  task automatic step();
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      step();
      if (wq.size() == 0 && dq.size() == 0) break;
    end
    total++;
    if (wq.size() != 0 || dq.size() != 0) begin
      $display("FAIL wait_idle: got %0d writes %0d dones pending expected 0", wq.size(), dq.size());
      wq.delete(); dq.delete();
    end else passed++;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, tlb_we, tlb_index, tlb_rd_index} !== '0)
      $display("FAIL reset_ctrl: got %b expected 0", {busy, done, tlb_we, tlb_index, tlb_rd_index});
    else passed++;
    total++;
    if (tlb_data !== '0) $display("FAIL reset_data: got %h expected 0", tlb_data);
    else passed++;
    total++;
    if (cp0_random !== 4'd15) $display("FAIL reset_random: got %0d expected 15", cp0_random);
    else passed++;
    total++;
    if ({probe_result, rd_entryhi, rd_entrylo0, rd_entrylo1} !== '0)
      $display("FAIL reset_results: got %h expected 0", {probe_result, rd_entryhi, rd_entrylo0, rd_entrylo1});
    else passed++;
  endtask

  task automatic test_random();
    logic [3:0] seq [5];
    seq = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd15};
    cp0_wired = 4'd12;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      total++;
      if (cp0_random !== seq[i]) $display("FAIL random_seq%0d: got %0d expected %0d", i, cp0_random, seq[i]);
      else passed++;
    end
    cp0_wired = 4'd15;
    repeat (3) step();
    total++;
    if (cp0_random !== 4'd15) $display("FAIL random_wired15: got %0d expected 15", cp0_random);
    else passed++;
    cp0_wired = 4'd12;
  endtask

  task automatic test_tlbwi();
    int d;
    issue(OP_TLBWI, 32'h0040_2000, 32'h0000_0046, 32'h0000_0086, 4'd5, d);
    wq.push_back('{d + 1, 4'd5, {19'h00201, 20'h00002, 1'b1, 1'b1, 20'h00001, 1'b1, 1'b1}});
    dq.push_back('{d + 2, OP_TLBWI, 32'h0, 32'h0, 32'h0, 32'h0});
    step();
    total++;
    if (busy !== 1'b1) $display("FAIL tlbwi_busy: got %b expected 1", busy);
    else passed++;
    wait_idle();
  endtask

  task automatic test_tlbp_hit();
    int d;
    for (int i = 0; i < 16; i++) mem[i] = {19'h00100 + 19'(i), 44'(i * 3)};
    mem[3][62:44] = 19'h12345;
    mem[9][62:44] = 19'h12345;
    issue(OP_TLBP, {19'h12345, 13'h1abc}, 32'h0, 32'h0, 4'd0, d);
    dq.push_back('{d + 5, OP_TLBP, 32'h0000_0003, 32'h0, 32'h0, 32'h0});
    wait_idle();
  endtask

  task automatic test_tlbp_miss();
    int d;
    issue(OP_TLBP, {19'h07777, 13'h0}, 32'h0, 32'h0, 4'd9, d);
    dq.push_back('{d + 17, OP_TLBP, 32'h8000_0000, 32'h0, 32'h0, 32'h0});
    for (int k = 1; k <= 16; k++) begin
      step();
      total++;
      if (tlb_rd_index !== 4'(k - 1)) $display("FAIL probe_scan%0d: got %0d expected %0d", k, tlb_rd_index, k - 1);
      else passed++;
    end
    wait_idle();
  endtask

  task automatic test_tlbr();
    int d;
    mem[7] = {19'h7FFFF, 20'hABCDE, 1'b1, 1'b0, 20'h12345, 1'b0, 1'b1};
    issue(OP_TLBR, 32'h0, 32'h0, 32'h0, 4'd7, d);
    dq.push_back('{d + 2, OP_TLBR, 32'h0, 32'hFFFF_E000, 32'h0048_D142, 32'h02AF_3784});
    step();
    total++;
    if (tlb_rd_index !== 4'd7) $display("FAIL tlbr_rd_index: got %0d expected 7", tlb_rd_index);
    else passed++;
    wait_idle();
    total++;
    if (probe_result !== 32'h8000_0000) $display("FAIL probe_hold: got %h expected 80000000", probe_result);
    else passed++;
  endtask

  task automatic test_tlbwr();
    int d;
    logic [31:0] hi, l0, l1;
    for (int n = 0; n < 2; n++) begin
      cp0_wired = (n == 0) ? 4'd12 : 4'd3;
      repeat (n * 4 + 1) step();
      hi = $urandom; l0 = $urandom; l1 = $urandom;
      issue(OP_TLBWR, hi, l0, l1, 4'd0, d);
      wq.push_back('{d + 1, rnd_m, exp_entry(hi, l0, l1)});
      dq.push_back('{d + 2, OP_TLBWR, 32'h0, 32'h0, 32'h0, 32'h0});
      wait_idle();
    end
    total++;
    if (rd_entryhi !== 32'hFFFF_E000) $display("FAIL tlbr_hold: got %h expected FFFFE000", rd_entryhi);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int d, d2, dn0, we0;
    logic [31:0] hi, l0, l1;
    dn0 = done_cnt; we0 = we_cnt;
    hi = 32'hABCD_E123; l0 = 32'h0123_4567; l1 = 32'h89AB_CDEF;
    issue(OP_TLBWI, hi, l0, l1, 4'd2, d);
    wq.push_back('{d + 1, 4'd2, exp_entry(hi, l0, l1)});
    dq.push_back('{d + 2, OP_TLBWI, 32'h0, 32'h0, 32'h0, 32'h0});
    @(negedge clk);
    op = OP_TLBP;
    @(negedge clk);
    op = OP_TLBWR;
    step();
    issue(OP_TLBR, 32'h0, 32'h0, 32'h0, 4'd2, d2);
    dq.push_back('{d2 + 2, OP_TLBR, 32'h0, {hi[31:13], 13'b0}, exp_lo(l0), exp_lo(l1)});
    wait_idle();
    total++;
    if (done_cnt - dn0 !== 2 || we_cnt - we0 !== 1)
      $display("FAIL back_to_back_counts: got %0d dones %0d writes expected 2 dones 1 write",
               done_cnt - dn0, we_cnt - we0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int d, dn0, we0;
    dn0 = done_cnt; we0 = we_cnt;
    issue(OP_TLBP, {19'h07777, 13'h0}, 32'h0, 32'h0, 4'd0, d);
    repeat (3) step();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) step();
    total++;
    if ({probe_result, rd_entryhi, busy} !== '0)
      $display("FAIL abort_state: got %h %h %b expected 0", probe_result, rd_entryhi, busy);
    else passed++;
    rst = 1'b0;
    issue(OP_TLBWI, 32'h1234_5000, 32'h40, 32'h40, 4'd1, d);
    step();
    rst = 1'b1;
    repeat (5) step();
    total++;
    if (done_cnt !== dn0 || we_cnt !== we0)
      $display("FAIL abort_counts: got %0d dones %0d writes expected 0 0", done_cnt - dn0, we_cnt - we0);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_random();
    test_tlbwi();
    test_tlbp_hit();
    test_tlbp_miss();
    test_tlbr();
    test_tlbwr();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tlb_maint.md
TLB_MAINT -- requirements
Module: tlb_maint

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-003 op_valid  in  1  one-cycle TLB-instruction request from MEM stage.
REQ-004 op  in  2  00 TLBWI, 01 TLBWR, 10 TLBP, 11 TLBR.
REQ-005 cp0_entryhi, cp0_entrylo0, cp0_entrylo1  in  32 each  CP0 operands; VPN2 = entryhi[31:13]; PFN = lo[25:6], D = lo[2], V = lo[1].
REQ-006 cp0_index  in  4  target entry for TLBWI/TLBR.
REQ-007 cp0_wired  in  4  lower bound for random replacement.
REQ-008 tlb_we, tlb_index[3:0], tlb_data[62:0]  out  write port to TLB array.
REQ-009 tlb_rd_index  out  4  read-port address; tlb_rd_data  in  63  combinational entry contents.
REQ-010 busy  out  1; done  out  1 (one-cycle pulse); stallreq  out  1 (= busy).
REQ-011 cp0_random  out  4  current Random value.
REQ-012 probe_result  out  32  {miss bit31, 27'b0, index[3:0]}; rd_entryhi, rd_entrylo0, rd_entrylo1  out  32 each  TLBR results.

Function
REQ-013 Entry packing SHALL be {VPN2[62:44], PFN1[43:24], D1[23], V1[22], PFN0[21:2], D0[1], V0[0]}.
REQ-014 FSM states IDLE, WRITE, PROBE, READ, DONE; op_valid is sampled only in IDLE; requests while busy are ignored, not queued.
REQ-015 IDLE + op_valid: latch operands, busy=1 next cycle; TLBWI/TLBWR -> WRITE, TLBP -> PROBE (scan idx=0), TLBR -> READ.
REQ-016 WRITE: tlb_we=1 for exactly one cycle; tlb_index = cp0_index (WI) or Random latched at acceptance (WR); tlb_data per REQ-013 from latched operands; -> DONE.
REQ-017 PROBE: tlb_rd_index=idx; one entry per cycle; match when tlb_rd_data[62:44] == latched VPN2; first (lowest) match -> DONE with probe_result = {0, idx}; no match at idx 15 -> DONE with probe_result = 32'h80000000.
REQ-018 READ: tlb_rd_index = latched index for one cycle; capture rd_entryhi = {VPN2, 13'b0}, rd_entrylo1/0 = {6'b0, PFN, 3'b0, D, V, 1'b0}; -> DONE.
REQ-019 DONE: done=1, busy=0, one cycle; -> IDLE. Results hold until the next op of the same type completes.
REQ-020 Latency (acceptance edge = cycle 0): write tlb_we cycle 1, done cycle 2; TLBR done cycle 2; TLBP match at entry k done cycle k+2, miss done cycle 17.
REQ-021 Random: decrements by 1 every cycle; when equal to cp0_wired, or less than cp0_wired, next value is 15; if cp0_wired = 15 it stays 15.
REQ-022 tlb_we SHALL be 0 in every state other than WRITE; tlb_rd_index = 0 when not in PROBE/READ.

Reset
REQ-023 rst=0 at any clock edge: state IDLE, busy=0, done=0, tlb_we=0, tlb_index=0, tlb_data=0, tlb_rd_index=0, cp0_random=15, probe_result=0, rd_entry* = 0.
REQ-024 Reset mid-operation aborts with no TLB write issued after the reset edge and no done pulse.

Structure
REQ-025 Op encodings, state encodings, entry field bit positions, TLBDataWidth (63) and TLBIndexNum (16) SHALL live in the shared defines file.
REQ-026 Random counter SHALL be a sub-module tlb_random (clk, rst, wired, random); the remainder is a single FSM.

Verification
REQ-027 TLBWI, index=5, entryhi=0x00402000, lo0=0x00000046, lo1=0x00000086 -> cycle 1 tlb_we=1, tlb_index=5, tlb_data = {19'h00201, 20'h00002, 1, 1, 20'h00001, 1, 1}; done cycle 2.
REQ-028 TLBP with VPN2 present at entries 3 and 9 -> probe_result=0x00000003, done at cycle 5.
REQ-029 TLBP with no match -> probe_result=0x80000000, done at cycle 17, tlb_rd_index visits 0..15 in order.
REQ-030 wired=12 after reset -> cp0_random sequence 15, 14, 13, 12, 15; TLBWR writes to the value held at acceptance.
REQ-031 TLBR index=7 with entry {VPN2=0x7FFFF, PFN1=0xABCDE, D1=1, V1=0, PFN0=0x12345, D0=0, V0=1} -> rd_entryhi=0xFFFFE000, rd_entrylo1=0x02AF3784, rd_entrylo0=0x0048D142.
REQ-032 rst=0 during PROBE cycle 4, or second op_valid while busy -> no done, tlb_we never asserted, second request dropped.
